core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 116 +++++++++++
 tb/tb_core_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// access and write-back, with per-access ready timeouts and a sticky error state.
module core_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  regwrite_in,
    input  logic                  pc_write_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    output logic                  regwrite_out,
    output logic                  pc_write_out,
    output logic [2:0]            state,
    output logic [31:0]           instr_count,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // The cycle in which the counter would reach TIMEOUT is the last chance for ready.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                st_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [31:0]           count_q;
    logic [7:0]            wait_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            st_q    <= S_IDLE;
            instr_q <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (en) begin
                        st_q   <= S_FETCH;
                        wait_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        st_q    <= S_DECODE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_q == WAIT_LAST) st_q <= S_ERROR;
                    end
                end
                S_DECODE: st_q <= S_EXEC;
                S_EXEC: begin
                    if (memread && memwrite) begin
                        st_q <= S_ERROR;
                    end else if (memread || memwrite) begin
                        st_q   <= S_MEM;
                        wait_q <= '0;
                    end else begin
                        st_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        st_q <= S_WB;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_q == WAIT_LAST) st_q <= S_ERROR;
                    end
                end
                S_WB: begin
                    count_q <= count_q + 32'd1;
                    if (en) begin
                        st_q   <= S_FETCH;
                        wait_q <= '0;
                    end else begin
                        st_q <= S_IDLE;
                    end
                end
                S_ERROR: st_q <= S_ERROR;
                default: st_q <= S_ERROR;
            endcase
        end
    end

    // Strobes are pure decodes of the current state so they can never outlive it.
    assign imem_req     = (st_q == S_FETCH);
    assign dmem_req     = (st_q == S_MEM);
    assign dmem_we      = (st_q == S_MEM) && memwrite;
    assign regwrite_out = (st_q == S_WB) && regwrite_in;
    assign pc_write_out = (st_q == S_WB) && pc_write_in;
    assign state        = st_q;
    assign instr        = instr_q;
    assign instr_count  = count_q;
    assign busy         = (st_q != S_IDLE) && (st_q != S_ERROR);
    assign err          = (st_q == S_ERROR);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer; expected state traces are
// built per instruction from phase lengths rather than from the FSM itself.
module tb_core_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERROR = 3'd6;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        en = 1'b0;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        memread = 1'b0, memwrite = 1'b0, regwrite_in = 1'b0, pc_write_in = 1'b0;
    logic        dmem_req, dmem_we;
    logic        dmem_ready = 1'b0;
    logic        regwrite_out, pc_write_out;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic        busy, err;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_count = '0;

    core_sequencer #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .arst_n(arst_n), .en(en),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .memread(memread), .memwrite(memwrite),
        .regwrite_in(regwrite_in), .pc_write_in(pc_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .regwrite_out(regwrite_out), .pc_write_out(pc_write_out),
        .state(state), .instr_count(instr_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        arst_n = 1'b0; en = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        memread = 1'b0; memwrite = 1'b0; regwrite_in = 1'b0; pc_write_in = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        exp_count = '0;
    endtask

    // One instruction: fd/md are ready delays in cycles, trace is derived from phase lengths.
    task automatic run_instr(input int fd, input int md, input bit mr, input bit mw,
                             input bit rw, input bit pw, input logic [31:0] data,
                             input bit drop_en, input string tag);
        logic [2:0] sts[$];
        int         ph[$];
        logic [6:0] exp_o, obs_o;
        for (int k = 0; k <= fd; k++) begin sts.push_back(ST_FETCH); ph.push_back(k); end
        sts.push_back(ST_DECODE); ph.push_back(0);
        sts.push_back(ST_EXEC);   ph.push_back(0);
        if (mr || mw)
            for (int k = 0; k <= md; k++) begin sts.push_back(ST_MEM); ph.push_back(k); end
        sts.push_back(ST_WB); ph.push_back(0);
        memread = mr; memwrite = mw; regwrite_in = rw; pc_write_in = pw;
        for (int i = 0; i < sts.size(); i++) begin
            @(negedge clk);
            total_cnt++;
            if (state !== sts[i])
                $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, state, sts[i]);
            else pass_cnt++;
            exp_o = {sts[i] == ST_FETCH, sts[i] == ST_MEM, sts[i] == ST_MEM && mw,
                     sts[i] == ST_WB && rw, sts[i] == ST_WB && pw, 1'b1, 1'b0};
            obs_o = {imem_req, dmem_req, dmem_we, regwrite_out, pc_write_out, busy, err};
            total_cnt++;
            if (obs_o !== exp_o)
                $display("FAIL %s outputs[%0d]: got %b want %b", tag, i, obs_o, exp_o);
            else pass_cnt++;
            if (sts[i] == ST_DECODE || sts[i] == ST_WB) begin
                total_cnt++;
                if (instr !== data) $display("FAIL %s instr: got %h want %h", tag, instr, data);
                else pass_cnt++;
            end
            if (i == 0 || sts[i] == ST_WB) begin
                total_cnt++;
                if (instr_count !== exp_count)
                    $display("FAIL %s instr_count: got %h want %h", tag, instr_count, exp_count);
                else pass_cnt++;
            end
            imem_ready = (sts[i] == ST_FETCH) ? (ph[i] == fd) : 1'($urandom);
            imem_rdata = (sts[i] == ST_FETCH && ph[i] == fd) ? data : $urandom;
            dmem_ready = (sts[i] == ST_MEM) ? (ph[i] == md) : 1'($urandom);
            if (drop_en && sts[i] == ST_DECODE) en = 1'b0;
            if (sts[i] == ST_WB) exp_count = exp_count + 32'd1;
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; en = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({state, instr, instr_count, imem_req, dmem_req, dmem_we, regwrite_out,
             pc_write_out, busy, err} !== '0)
            $display("FAIL reset_outputs: state=%0d instr=%h cnt=%h busy=%b err=%b want all 0",
                     state, instr, instr_count, busy, err);
        else pass_cnt++;
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (state !== ST_IDLE || busy !== 1'b0) $display("FAIL idle_hold: state=%0d busy=%b want 0/0", state, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        run_instr(0, 0, 0, 0, 1, 0, 32'h0050_0093, 0, "basic");
        @(negedge clk);
        total_cnt++;
        if (state !== ST_FETCH || instr_count !== 32'd1)
            $display("FAIL basic_next: state=%0d cnt=%0d want 1/1", state, instr_count);
        else pass_cnt++;
    endtask

    task automatic test_load_store();
        do_reset();
        en = 1'b1;
        run_instr(0, 3, 1, 0, 1, 0, $urandom, 0, "load");
        run_instr(2, 1, 0, 1, 0, 1, $urandom, 0, "store");
        run_instr(3, 3, 1, 0, 1, 1, $urandom, 1, "ready_last");
        @(negedge clk);
        total_cnt++;
        if (state !== ST_IDLE || instr_count !== 32'd3 || err !== 1'b0)
            $display("FAIL loadstore_end: state=%0d cnt=%0d err=%b want 0/3/0", state, instr_count, err);
        else pass_cnt++;
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        en = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (state !== ST_FETCH || imem_req !== 1'b1)
                $display("FAIL fetch_wait[%0d]: state=%0d req=%b want 1/1", i, state, imem_req);
            else pass_cnt++;
            @(negedge clk);
        end
        imem_ready = 1'b1; dmem_ready = 1'b1; memread = 1'b1; regwrite_in = 1'b1; pc_write_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({state, imem_req, dmem_req, dmem_we, regwrite_out, pc_write_out, busy, err}
                    !== {ST_ERROR, 7'b0000001})
                $display("FAIL fetch_error[%0d]: state=%0d busy=%b err=%b want 6/0/1", i, state, busy, err);
            else pass_cnt++;
            @(negedge clk);
        end
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (state !== ST_IDLE || err !== 1'b0) $display("FAIL error_reset: state=%0d err=%b want 0/0", state, err);
        else pass_cnt++;
    endtask

    task automatic test_mem_errors();
        logic [2:0] seq_to[8] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_ERROR};
        logic [2:0] seq_bm[5] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_ERROR, ST_ERROR};
        do_reset();
        en = 1'b1; imem_ready = 1'b1; memread = 1'b1; dmem_ready = 1'b0;
        foreach (seq_to[i]) begin
            @(negedge clk);
            total_cnt++;
            if (state !== seq_to[i] || dmem_req !== (seq_to[i] == ST_MEM))
                $display("FAIL mem_timeout[%0d]: state=%0d req=%b want %0d", i, state, dmem_req, seq_to[i]);
            else pass_cnt++;
        end
        do_reset();
        en = 1'b1; imem_ready = 1'b1; memread = 1'b1; memwrite = 1'b1;
        regwrite_in = 1'b1; pc_write_in = 1'b1; dmem_ready = 1'b1;
        foreach (seq_bm[i]) begin
            @(negedge clk);
            total_cnt++;
            if (state !== seq_bm[i] || regwrite_out !== 1'b0 || pc_write_out !== 1'b0 || dmem_req !== 1'b0)
                $display("FAIL both_mem[%0d]: state=%0d rw=%b pw=%b want %0d/0/0",
                         i, state, regwrite_out, pc_write_out, seq_bm[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_en_drop_and_reset_mid_mem();
        do_reset();
        en = 1'b1;
        run_instr(1, 0, 0, 0, 1, 1, $urandom, 1, "en_drop");
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if (state !== ST_IDLE || busy !== 1'b0 || instr_count !== 32'd1)
                $display("FAIL en_drop_idle: state=%0d busy=%b cnt=%0d want 0/0/1", state, busy, instr_count);
            else pass_cnt++;
        end
        en = 1'b1; imem_ready = 1'b1; memread = 1'b1; dmem_ready = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (state !== ST_MEM || dmem_req !== 1'b1) $display("FAIL mid_mem: state=%0d want 4", state);
        else pass_cnt++;
        arst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (state !== ST_IDLE || dmem_req !== 1'b0 || instr_count !== 32'd0 || instr !== 32'd0)
            $display("FAIL reset_mid_mem: state=%0d req=%b cnt=%0d instr=%h want all 0",
                     state, dmem_req, instr_count, instr);
        else pass_cnt++;
        arst_n = 1'b1;
    endtask

    task automatic test_count_wrap();
        do_reset();
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        exp_count = 32'hFFFF_FFFF;
        en = 1'b1;
        run_instr(0, 0, 0, 0, 0, 0, $urandom, 1, "wrap");
        @(negedge clk);
        total_cnt++;
        if (instr_count !== 32'd0) $display("FAIL count_wrap: got %h want 00000000", instr_count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int n, kind;
        do_reset();
        en = 1'b1;
        n = 40;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 2);
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), kind == 1, kind == 2,
                      1'($urandom), 1'($urandom), $urandom, i == n - 1, "random");
        end
        @(negedge clk);
        total_cnt++;
        if (state !== ST_IDLE || instr_count !== 32'(n))
            $display("FAIL random_end: state=%0d cnt=%0d want 0/%0d", state, instr_count, n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_store();
        test_fetch_timeout();
        test_mem_errors();
        test_en_drop_and_reset_mid_mem();
        test_count_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
